// File: rtl/rv_iopmp_err_capture.sv
// rv_iopmp_pkg / rv_iopmp_err_capture
//
// Receiving end of the IOPMP error-capture interface. The first accepted
// violation is latched into the ERR_REQINFO / ERR_REQID / ERR_REQADDR(H)
// holding registers. Further violations while a record is pending only set
// the svc flag and bump a saturating counter. Software clears the record
// with a one-cycle write-1-to-clear pulse. irq_o is either a level
// (valid & ie) or a registered one-cycle pulse per capture.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   err_interface_i   error record from the checker (qualified by error_detected)
//   err_clear_i       W1C of the pending record
//   ie_i              interrupt enable
//   suppress_i        ignore incoming errors while high
//   err_*_o           captured record, svc flag and svc counter
//   irq_o             interrupt

package rv_iopmp_pkg;

  typedef struct packed {
    logic        error_detected;
    logic [1:0]  ttype;
    logic [2:0]  etype;
    logic [31:0] sid;        // modules use the low SID_WIDTH bits
    logic [15:0] eid;
    logic [31:0] reqaddr;
    logic [31:0] reqaddrh;
  } error_capture_t;

endpackage

module rv_iopmp_err_capture #(
  parameter int unsigned SID_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter bit          IRQ_PULSE = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  rv_iopmp_pkg::error_capture_t err_interface_i,
  input  logic                         err_clear_i,
  input  logic                         ie_i,
  input  logic                         suppress_i,
  output logic                         err_valid_o,
  output logic [1:0]                   err_ttype_o,
  output logic [2:0]                   err_etype_o,
  output logic [SID_WIDTH-1:0]         err_sid_o,
  output logic [15:0]                  err_eid_o,
  output logic [63:0]                  err_reqaddr_o,
  output logic                         err_svc_o,
  output logic [CNT_WIDTH-1:0]         err_svc_cnt_o,
  output logic                         irq_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           ttype_q, ttype_d;
  logic [2:0]           etype_q, etype_d;
  logic [SID_WIDTH-1:0] sid_q, sid_d;
  logic [15:0]          eid_q, eid_d;
  logic [63:0]          addr_q, addr_d;
  logic                 svc_q, svc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 irq_pulse_q, irq_pulse_d;

  logic accept;
  logic capture;

  assign accept = err_interface_i.error_detected & ~suppress_i;

  always_comb begin
    state_d     = state_q;
    ttype_d     = ttype_q;
    etype_d     = etype_q;
    sid_d       = sid_q;
    eid_d       = eid_q;
    addr_d      = addr_q;
    svc_d       = svc_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          capture = 1'b1;
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        if (accept && err_clear_i) begin
          // Clear and new error together: the new record replaces the old.
          capture = 1'b1;
          svc_d   = 1'b0;
          cnt_d   = '0;
        end else if (accept) begin
          svc_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (err_clear_i) begin
          state_d = IDLE;
          svc_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      ttype_d = err_interface_i.ttype;
      etype_d = err_interface_i.etype;
      sid_d   = err_interface_i.sid[SID_WIDTH-1:0];
      eid_d   = err_interface_i.eid;
      addr_d  = {err_interface_i.reqaddrh, err_interface_i.reqaddr};
    end

    irq_pulse_d = capture & ie_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ttype_q     <= '0;
      etype_q     <= '0;
      sid_q       <= '0;
      eid_q       <= '0;
      addr_q      <= '0;
      svc_q       <= 1'b0;
      cnt_q       <= '0;
      irq_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ttype_q     <= ttype_d;
      etype_q     <= etype_d;
      sid_q       <= sid_d;
      eid_q       <= eid_d;
      addr_q      <= addr_d;
      svc_q       <= svc_d;
      cnt_q       <= cnt_d;
      irq_pulse_q <= irq_pulse_d;
    end
  end

  assign err_valid_o   = (state_q == CAPTURED);
  assign err_ttype_o   = ttype_q;
  assign err_etype_o   = etype_q;
  assign err_sid_o     = sid_q;
  assign err_eid_o     = eid_q;
  assign err_reqaddr_o = addr_q;
  assign err_svc_o     = svc_q;
  assign err_svc_cnt_o = cnt_q;
  assign irq_o         = IRQ_PULSE ? irq_pulse_q : (err_valid_o & ie_i);

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
module tb_rv_iopmp_err_capture;

  logic clk;
  logic rst;
  rv_iopmp_pkg::error_capture_t err;
  logic clr;
  logic ie;
  logic sup;

  // dut0: level irq, 8-bit counter
  logic        v0;
  logic [1:0]  tt0;
  logic [2:0]  et0;
  logic [7:0]  sid0;
  logic [15:0] eid0;
  logic [63:0] addr0;
  logic        svc0;
  logic [7:0]  cnt0;
  logic        irq0;

  // dut1: pulse irq, 2-bit counter
  logic        v1;
  logic [1:0]  tt1;
  logic [2:0]  et1;
  logic [7:0]  sid1;
  logic [15:0] eid1;
  logic [63:0] addr1;
  logic        svc1;
  logic [1:0]  cnt1;
  logic        irq1;

  int checks = 0;
  int errors = 0;

  rv_iopmp_err_capture #(.SID_WIDTH(8), .CNT_WIDTH(8), .IRQ_PULSE(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .err_interface_i(err), .err_clear_i(clr),
    .ie_i(ie), .suppress_i(sup), .err_valid_o(v0), .err_ttype_o(tt0),
    .err_etype_o(et0), .err_sid_o(sid0), .err_eid_o(eid0),
    .err_reqaddr_o(addr0), .err_svc_o(svc0), .err_svc_cnt_o(cnt0), .irq_o(irq0)
  );

  rv_iopmp_err_capture #(.SID_WIDTH(8), .CNT_WIDTH(2), .IRQ_PULSE(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .err_interface_i(err), .err_clear_i(clr),
    .ie_i(ie), .suppress_i(sup), .err_valid_o(v1), .err_ttype_o(tt1),
    .err_etype_o(et1), .err_sid_o(sid1), .err_eid_o(eid1),
    .err_reqaddr_o(addr1), .err_svc_o(svc1), .err_svc_cnt_o(cnt1), .irq_o(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_err(input logic d, input logic [1:0] tt, input logic [2:0] et,
                         input logic [31:0] s, input logic [15:0] e,
                         input logic [31:0] a, input logic [31:0] ah);
    err.error_detected = d;
    err.ttype          = tt;
    err.etype          = et;
    err.sid            = s;
    err.eid            = e;
    err.reqaddr        = a;
    err.reqaddrh       = ah;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    ie  = 1'b0;
    sup = 1'b0;
    set_err(1'b0, 2'd0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", {63'd0, v0}, 64'd0);
    chk("rst_addr0", addr0, 64'd0);
    chk("rst_cnt0", {56'd0, cnt0}, 64'd0);
    chk("rst_irq1", {63'd0, irq1}, 64'd0);
    rst = 1'b0;

    // First capture
    ie = 1'b1;
    set_err(1'b1, 2'd2, 3'd3, 32'h5A, 16'd7, 32'h8000_0010, 32'h1);
    step();
    set_err(1'b0, 2'd0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    chk("cap_valid", {63'd0, v0}, 64'd1);
    chk("cap_addr", addr0, 64'h0000_0001_8000_0010);
    chk("cap_sid", {56'd0, sid0}, 64'h5A);
    chk("cap_eid", {48'd0, eid0}, 64'd7);
    chk("cap_ttype", {62'd0, tt0}, 64'd2);
    chk("cap_etype", {61'd0, et0}, 64'd3);
    chk("cap_irq_lvl", {63'd0, irq0}, 64'd1);
    chk("cap_irq_pulse", {63'd0, irq1}, 64'd1);
    step();
    chk("pulse_end", {63'd0, irq1}, 64'd0);
    chk("lvl_hold", {63'd0, irq0}, 64'd1);
    ie = 1'b0;
    #1;
    chk("ie_mask", {63'd0, irq0}, 64'd0);
    ie = 1'b1;
    #1;
    chk("ie_unmask", {63'd0, irq0}, 64'd1);

    // Three subsequent violations
    set_err(1'b1, 2'd1, 3'd5, 32'h33, 16'd9, 32'h1234_5678, 32'hABCD);
    step(); step(); step();
    set_err(1'b0, 2'd0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    chk("svc_eid_keep", {48'd0, eid0}, 64'd7);
    chk("svc_sid_keep", {56'd0, sid0}, 64'h5A);
    chk("svc_addr_keep", addr0, 64'h0000_0001_8000_0010);
    chk("svc_flag", {63'd0, svc0}, 64'd1);
    chk("svc_cnt3", {56'd0, cnt0}, 64'd3);
    chk("svc_cnt3_w2", {62'd0, cnt1}, 64'd3);
    chk("svc_no_pulse", {63'd0, irq1}, 64'd0);

    // Three more: 6 total, 2-bit counter saturates
    set_err(1'b1, 2'd1, 3'd5, 32'h33, 16'd9, 32'h1234_5678, 32'hABCD);
    step(); step(); step();
    set_err(1'b0, 2'd0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    chk("svc_cnt6", {56'd0, cnt0}, 64'd6);
    chk("svc_sat_w2", {62'd0, cnt1}, 64'd3);

    // Clear
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_valid", {63'd0, v0}, 64'd0);
    chk("clr_svc", {63'd0, svc0}, 64'd0);
    chk("clr_cnt", {56'd0, cnt0}, 64'd0);
    chk("clr_irq", {63'd0, irq0}, 64'd0);
    chk("clr_keep_eid", {48'd0, eid0}, 64'd7);

    // Capture eid=9, one svc, then clear together with new error eid=2
    set_err(1'b1, 2'd0, 3'd1, 32'h11, 16'd9, 32'h100, 32'h0);
    step();
    chk("cap9_eid", {48'd0, eid0}, 64'd9);
    set_err(1'b1, 2'd0, 3'd1, 32'h22, 16'd5, 32'h200, 32'h0);
    step();
    chk("cap9_svc_cnt", {56'd0, cnt0}, 64'd1);
    chk("cap9_pulse_off", {63'd0, irq1}, 64'd0);
    clr = 1'b1;
    set_err(1'b1, 2'd3, 3'd2, 32'h44, 16'd2, 32'h300, 32'h2);
    step();
    clr = 1'b0;
    set_err(1'b0, 2'd0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    chk("cwe_valid", {63'd0, v0}, 64'd1);
    chk("cwe_eid", {48'd0, eid0}, 64'd2);
    chk("cwe_addr", addr0, 64'h0000_0002_0000_0300);
    chk("cwe_cnt", {56'd0, cnt0}, 64'd0);
    chk("cwe_svc", {63'd0, svc0}, 64'd0);
    chk("cwe_pulse", {63'd0, irq1}, 64'd1);
    step();
    chk("cwe_pulse_end", {63'd0, irq1}, 64'd0);

    // Clear, then suppressed error while idle
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr2_valid", {63'd0, v0}, 64'd0);
    step();
    chk("idle_clr_valid", {63'd0, v0}, 64'd0);
    sup = 1'b1;
    set_err(1'b1, 2'd1, 3'd1, 32'h66, 16'd4, 32'h400, 32'h0);
    step();
    chk("sup_valid", {63'd0, v0}, 64'd0);
    chk("sup_eid_keep", {48'd0, eid0}, 64'd2);
    sup = 1'b0;
    step();
    chk("unsup_cap", {63'd0, v0}, 64'd1);
    chk("unsup_eid", {48'd0, eid0}, 64'd4);
    // Suppressed errors with a record pending: no svc, irq not masked
    sup = 1'b1;
    step();
    chk("sup_no_svc", {63'd0, svc0}, 64'd0);
    chk("sup_irq", {63'd0, irq0}, 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    sup = 1'b0;
    set_err(1'b0, 2'd0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    chk("sup_clr_valid", {63'd0, v0}, 64'd0);

    // Asynchronous reset while a record is pending
    set_err(1'b1, 2'd2, 3'd4, 32'h77, 16'd3, 32'hDEAD_BEEF, 32'h5);
    step();
    set_err(1'b0, 2'd0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    chk("pre_rst_valid", {63'd0, v0}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, v0}, 64'd0);
    chk("arst_addr", addr0, 64'd0);
    chk("arst_eid", {48'd0, eid0}, 64'd0);
    chk("arst_irq", {63'd0, irq0}, 64'd0);
    chk("arst_sid1", {56'd0, sid1}, 64'd0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
